branch_predictor_gshare: RTL and testbench

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

---
 rtl/bp_pkg.sv | 14 +
 rtl/bp_btb.sv | 48 ++++
 rtl/branch_predictor_gshare.sv | 149 ++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: table-indexing mode
// encodings and the saturating-counter reset value.
package bp_pkg;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Weakly-not-taken value for a counter of the given width, i.e. the
    // largest value whose MSB is still zero.
    function automatic logic [3:0] ctrResetValue(input int ctrBits);
        ctrResetValue = 4'((1 << (ctrBits - 1)) - 1);
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: direct-mapped tag/valid/target arrays with one
// combinational read port and one synchronous write port.
module bp_btb #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rdIdx,
    input  logic [TAG_BITS-1:0] rdTag,
    output logic                rdHit,
    output logic [XLEN-1:0]     rdTarget,
    input  logic                wrEn,
    input  logic [IDX_BITS-1:0] wrIdx,
    input  logic [TAG_BITS-1:0] wrTag,
    input  logic [XLEN-1:0]     wrTarget
);

    logic [ENTRIES-1:0]  validBits;
    logic [TAG_BITS-1:0] tagArray    [ENTRIES];
    logic [XLEN-1:0]     targetArray [ENTRIES];

    // Valid bits are the only BTB state that needs clearing on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            validBits <= '0;
        end else if (wrEn) begin
            validBits[wrIdx] <= 1'b1;
        end
    end

    // Tag and target payload; meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (rst && wrEn) begin
            tagArray[wrIdx]    <= wrTag;
            targetArray[wrIdx] <= wrTarget;
        end
    end

    // A hit needs a valid entry whose stored tag matches the lookup tag.
    always_comb begin
        rdHit    = validBits[rdIdx] && (tagArray[rdIdx] == rdTag);
        rdTarget = targetArray[rdIdx];
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Bimodal/gshare direction predictor with BTB. Prediction is purely
// combinational from the fetch PC; training happens on resolved branches
// using the history snapshot that travelled with the branch.
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 6,
    parameter int MODE     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     fetch_pc,
    output logic                predict_taken,
    output logic [XLEN-1:0]     predict_target,
    output logic [GHR_BITS-1:0] predict_ghr,
    input  logic                upd_en,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         mispredict_cnt
);

    localparam int IDX      = $clog2(ENTRIES);
    localparam int TAG_BITS = XLEN - IDX - 2;
    localparam logic [3:0]          CTR_INIT_FULL = ctrResetValue(CTR_BITS);
    localparam logic [CTR_BITS-1:0] CTR_INIT      = CTR_INIT_FULL[CTR_BITS-1:0];
    localparam logic [CTR_BITS-1:0] CTR_MAX       = {CTR_BITS{1'b1}};

    logic [CTR_BITS-1:0] ctrTable [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic                rstSeen;

    logic [IDX-1:0]      fetchPcIdx;
    logic [IDX-1:0]      updPcIdx;
    logic [IDX-1:0]      fetchIdx;
    logic [IDX-1:0]      updIdx;
    logic [TAG_BITS-1:0] fetchTag;
    logic [TAG_BITS-1:0] updTag;
    logic                btbHit;
    logic [XLEN-1:0]     btbTarget;
    logic                predictEnable;
    logic [GHR_BITS-1:0] ghrShiftLive;
    logic [GHR_BITS-1:0] ghrShiftRepair;
    logic                unusedPcBits;

    assign fetchPcIdx   = fetch_pc[IDX+1:2];
    assign updPcIdx     = upd_pc[IDX+1:2];
    assign fetchTag     = fetch_pc[XLEN-1:IDX+2];
    assign updTag       = upd_pc[XLEN-1:IDX+2];
    assign unusedPcBits = ^{fetch_pc[1:0], upd_pc[1:0]};

    // Training uses the carried snapshot, never the live history, so the
    // update touches the same counter the prediction read.
    assign fetchIdx = (MODE == BP_GSHARE) ? (fetchPcIdx ^ IDX'(ghr))     : fetchPcIdx;
    assign updIdx   = (MODE == BP_GSHARE) ? (updPcIdx   ^ IDX'(upd_ghr)) : updPcIdx;

    if (GHR_BITS == 1) begin : gHistOne
        assign ghrShiftLive   = upd_taken;
        assign ghrShiftRepair = upd_taken;
    end else begin : gHistMany
        assign ghrShiftLive   = {ghr[GHR_BITS-2:0], upd_taken};
        assign ghrShiftRepair = {upd_ghr[GHR_BITS-2:0], upd_taken};
    end

    bp_btb #(
        .XLEN     (XLEN),
        .ENTRIES  (ENTRIES),
        .IDX_BITS (IDX),
        .TAG_BITS (TAG_BITS)
    ) btb (
        .clk      (clk),
        .rst      (rst),
        .rdIdx    (fetchPcIdx),
        .rdTag    (fetchTag),
        .rdHit    (btbHit),
        .rdTarget (btbTarget),
        .wrEn     (upd_en && upd_taken),
        .wrIdx    (updPcIdx),
        .wrTag    (updTag),
        .wrTarget (upd_target)
    );

    // Remembers that at least one edge has sampled reset deasserted, so
    // predictions stay quiet through the first cycle after release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rstSeen <= 1'b0;
        end else begin
            rstSeen <= 1'b1;
        end
    end

    // Saturating direction counters, trained by resolved branches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctrTable[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (ctrTable[updIdx] != CTR_MAX) begin
                    ctrTable[updIdx] <= ctrTable[updIdx] + 1'b1;
                end
            end else if (ctrTable[updIdx] != '0) begin
                ctrTable[updIdx] <= ctrTable[updIdx] - 1'b1;
            end
        end
    end

    // Global history: shift in each outcome; a mispredict rebuilds it from
    // the carried snapshot to discard speculative divergence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr <= '0;
        end else if (upd_en) begin
            ghr <= upd_mispredict ? ghrShiftRepair : ghrShiftLive;
        end
    end

    // Saturating performance counters for resolved branches and mispredicts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (upd_en) begin
            if (branch_cnt != 32'hFFFF_FFFF) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (upd_mispredict && (mispredict_cnt != 32'hFFFF_FFFF)) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

    // Prediction outputs, held at zero during reset and the cycle after.
    always_comb begin
        predictEnable  = rst && rstSeen;
        predict_taken  = predictEnable && ctrTable[fetchIdx][CTR_BITS-1] && btbHit;
        predict_target = predictEnable ? btbTarget : '0;
        predict_ghr    = predictEnable ? ghr : '0;
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: a bimodal and a gshare instance share one stimulus
// stream; expected values are hand-computed constants.
module tb_branch_predictor_gshare;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [5:0]  upd_ghr;
    logic        upd_mispredict;

    logic        takenBi,  takenGs;
    logic [31:0] targetBi, targetGs;
    logic [5:0]  ghrBi,    ghrGs;
    logic [31:0] branchBi, branchGs;
    logic [31:0] mispBi,   mispGs;

    int checkCount;
    int errorCount;
    logic [5:0] modelGhr;

    branch_predictor_gshare #(.XLEN(32), .ENTRIES(64), .CTR_BITS(2), .GHR_BITS(6), .MODE(0)) dutBi (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .predict_taken(takenBi), .predict_target(targetBi), .predict_ghr(ghrBi),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
        .branch_cnt(branchBi), .mispredict_cnt(mispBi)
    );

    branch_predictor_gshare #(.XLEN(32), .ENTRIES(64), .CTR_BITS(2), .GHR_BITS(6), .MODE(1)) dutGs (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .predict_taken(takenGs), .predict_target(targetGs), .predict_ghr(ghrGs),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
        .branch_cnt(branchGs), .mispredict_cnt(mispGs)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One resolved-branch update, held for exactly one rising edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                                 input logic [5:0] hist, input logic mis);
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = target;
        upd_ghr        = hist;
        upd_mispredict = mis;
        upd_en         = 1'b1;
        @(posedge clk);
        #1;
        upd_en = 1'b0;
        if (mis) modelGhr = {hist[4:0], taken};
        else     modelGhr = {modelGhr[4:0], taken};
    endtask

    // Directed sequence.
    initial begin
        checkCount = 0;
        errorCount = 0;
        modelGhr   = '0;
        fetch_pc   = 32'h100;

        // Reset asserted with a colliding update that must be lost.
        rst = 1'b0; upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
        upd_target = 32'h200; upd_ghr = 6'd0; upd_mispredict = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_taken",  {31'd0, takenBi}, 32'd0);
        checkOutput("rst_target", targetBi, 32'd0);
        checkOutput("rst_ghr",    {26'd0, ghrGs}, 32'd0);

        rst = 1'b1; upd_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_taken", {31'd0, takenBi}, 32'd0);
        checkOutput("post_rst_ghr",   {26'd0, ghrBi}, 32'd0);
        checkOutput("post_rst_bcnt",  branchBi, 32'd0);
        checkOutput("post_rst_mcnt",  mispGs, 32'd0);

        // Two taken updates train the bimodal entry to strongly taken.
        repeat (2) applyStimulus(32'h100, 1'b1, 32'h200, modelGhr, 1'b0);
        checkOutput("train_taken",    {31'd0, takenBi}, 32'd1);
        checkOutput("train_target",   targetBi, 32'h200);
        checkOutput("train_ghr",      {26'd0, ghrBi}, 32'h03);
        checkOutput("train_bcnt",     branchBi, 32'd2);
        checkOutput("gs_train_taken", {31'd0, takenGs}, 32'd0);

        // Saturation at 3, then weak taken, then not taken.
        repeat (5) applyStimulus(32'h100, 1'b1, 32'h200, modelGhr, 1'b0);
        checkOutput("gs_sat_taken", {31'd0, takenGs}, 32'd1);
        checkOutput("sat_ghr",      {26'd0, ghrBi}, 32'h3F);
        applyStimulus(32'h100, 1'b0, 32'h0, modelGhr, 1'b0);
        checkOutput("sat_weak_taken", {31'd0, takenBi}, 32'd1);
        repeat (2) applyStimulus(32'h100, 1'b0, 32'h0, modelGhr, 1'b0);
        checkOutput("sat_not_taken", {31'd0, takenBi}, 32'd0);
        checkOutput("sat_bcnt",      branchBi, 32'd10);

        // Retrain, then probe a PC sharing the index but not the tag.
        repeat (2) applyStimulus(32'h100, 1'b1, 32'h200, modelGhr, 1'b0);
        checkOutput("retrain_taken", {31'd0, takenBi}, 32'd1);
        fetch_pc = 32'h200;
        #1;
        checkOutput("tag_miss_taken", {31'd0, takenBi}, 32'd0);

        // Build GHR = 101010 with an alternating pattern on another branch.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'h104, (i % 2) == 0, 32'h400, modelGhr, 1'b0);
        end
        checkOutput("pattern_ghr",  {26'd0, ghrGs}, 32'h2A);
        checkOutput("pattern_bcnt", branchGs, 32'd18);

        // Mispredict repair from the carried snapshot.
        applyStimulus(32'h104, 1'b1, 32'h500, 6'b000011, 1'b1);
        checkOutput("repair_ghr_gs", {26'd0, ghrGs}, 32'h07);
        checkOutput("repair_ghr_bi", {26'd0, ghrBi}, 32'h07);
        checkOutput("repair_mcnt",   mispGs, 32'd1);
        checkOutput("repair_bcnt",   branchGs, 32'd19);
        fetch_pc = 32'h104;
        #1;
        checkOutput("repair_bi_taken",  {31'd0, takenBi}, 32'd1);
        checkOutput("repair_bi_target", targetBi, 32'h500);
        checkOutput("repair_gs_taken",  {31'd0, takenGs}, 32'd0);

        // Update inputs must be ignored while upd_en is low.
        upd_pc = 32'h104; upd_taken = 1'b0; upd_target = 32'h0;
        upd_ghr = 6'h3F; upd_mispredict = 1'b1; upd_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_bcnt",  branchBi, 32'd19);
        checkOutput("idle_mcnt",  mispBi, 32'd1);
        checkOutput("idle_ghr",   {26'd0, ghrBi}, 32'h07);
        checkOutput("idle_taken", {31'd0, takenBi}, 32'd1);

        // Reset collision: update during reset is dropped.
        rst = 1'b0; upd_en = 1'b1; upd_pc = 32'h104; upd_taken = 1'b1;
        upd_target = 32'h600; upd_ghr = 6'h01; upd_mispredict = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("coll_rst_taken",  {31'd0, takenBi}, 32'd0);
        checkOutput("coll_rst_target", targetBi, 32'd0);
        checkOutput("coll_rst_ghr",    {26'd0, ghrBi}, 32'd0);
        rst = 1'b1; upd_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("coll_bcnt",  branchBi, 32'd0);
        checkOutput("coll_mcnt",  mispGs, 32'd0);
        checkOutput("coll_taken", {31'd0, takenBi}, 32'd0);
        checkOutput("coll_ghr",   {26'd0, ghrGs}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
